// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer write controller.
// Holds pixel/address typedefs, FSM and grant enums, and the (x,y) address map.
package fb_pkg;

    typedef logic [23:0] pixel_t;
    typedef logic [15:0] fb_adr_t;

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

    typedef enum logic {
        GNT_HOST,
        GNT_FILL
    } grant_t;

    // Linear address y*FB_W + x for a power-of-two width: pure shift/concat.
    function automatic logic [31:0] fb_addr(
        input logic [7:0] x,
        input logic [7:0] y,
        input int         xbits
    );
        return (32'(y) << xbits) | 32'(x);
    endfunction

endpackage

// File: rtl/fb_rect_walker.sv
// Rectangle walker: normalises/clips fill corners and steps (cx,cy) row by row.
// Ports: i_clk, i_rst, i_load + corners, i_step; o_cx, o_cy, o_last, o_empty.
module fb_rect_walker #(
    parameter int FB_W = 256,
    parameter int FB_H = 256
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_x0,
    input  logic [7:0] i_y0,
    input  logic [7:0] i_x1,
    input  logic [7:0] i_y1,
    input  logic       i_step,
    output logic [7:0] o_cx,
    output logic [7:0] o_cy,
    output logic       o_last,
    output logic       o_empty
);

    localparam logic [8:0] XMAX = 9'(FB_W - 1);
    localparam logic [8:0] YMAX = 9'(FB_H - 1);

    logic [7:0] w_xa;
    logic [7:0] w_xb_raw;
    logic [7:0] w_xb;
    logic [7:0] w_ya;
    logic [7:0] w_yb_raw;
    logic [7:0] w_yb;

    logic [7:0] r_xa;
    logic [7:0] r_xb;
    logic [7:0] r_yb;
    logic [7:0] r_cx;
    logic [7:0] r_cy;

    assign w_xa     = (i_x0 < i_x1) ? i_x0 : i_x1;
    assign w_xb_raw = (i_x0 < i_x1) ? i_x1 : i_x0;
    assign w_ya     = (i_y0 < i_y1) ? i_y0 : i_y1;
    assign w_yb_raw = (i_y0 < i_y1) ? i_y1 : i_y0;

    assign w_xb = ({1'b0, w_xb_raw} > XMAX) ? XMAX[7:0] : w_xb_raw;
    assign w_yb = ({1'b0, w_yb_raw} > YMAX) ? YMAX[7:0] : w_yb_raw;

    // Rectangle lies entirely off-screen: nothing to write.
    assign o_empty = ({1'b0, w_xa} > XMAX) || ({1'b0, w_ya} > YMAX);

    assign o_cx   = r_cx;
    assign o_cy   = r_cy;
    assign o_last = (r_cx == r_xb) && (r_cy == r_yb);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_xa <= '0;
            r_xb <= '0;
            r_yb <= '0;
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_load) begin
            r_xa <= w_xa;
            r_xb <= w_xb;
            r_yb <= w_yb;
            r_cx <= w_xa;
            r_cy <= w_ya;
        end else if (i_step) begin
            if (r_cx == r_xb) begin
                r_cx <= r_xa;
                r_cy <= r_cy + 8'd1;
            end else begin
                r_cx <= r_cx + 8'd1;
            end
        end
    end

endmodule

// File: rtl/fb_write_ctrl.sv
// Framebuffer write-port controller: arbitrates host pixel writes and rect fill.
// Ports: CLOCK_50/rst, host valid/ready/x/y/color, fill ctrl, fb_wclk/wadr/we/d.
module fb_write_ctrl
    import fb_pkg::*;
#(
    parameter int FB_W  = 256,
    parameter int FB_H  = 256,
    parameter int ADR_W = 16,
    parameter int PIX_W = 24
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [7:0]       host_x,
    input  logic [7:0]       host_y,
    input  logic [PIX_W-1:0] host_color,
    input  logic             fill_start,
    input  logic             fill_abort,
    input  logic [7:0]       fill_x0,
    input  logic [7:0]       fill_y0,
    input  logic [7:0]       fill_x1,
    input  logic [7:0]       fill_y1,
    input  logic [PIX_W-1:0] fill_color,
    output logic             fill_busy,
    output logic             fill_done,
    output logic             fb_wclk,
    output logic [ADR_W-1:0] fb_wadr,
    output logic             fb_we,
    output logic [PIX_W-1:0] fb_d
);

    localparam int XBITS = $clog2(FB_W);

    fill_state_t r_state;
    fill_state_t w_next;
    grant_t      r_last_grant;

    logic             w_gnt_host;
    logic             w_gnt_fill;
    logic             w_load;
    logic             w_empty_done;
    logic             w_host_ok;
    logic [7:0]       w_cx;
    logic [7:0]       w_cy;
    logic             w_last;
    logic             w_empty;

    logic             r_we;
    logic [ADR_W-1:0] r_adr;
    logic [PIX_W-1:0] r_d;
    logic             r_done;
    logic [PIX_W-1:0] r_fill_color;

    fb_rect_walker #(
        .FB_W (FB_W),
        .FB_H (FB_H)
    ) u_walker (
        .i_clk   (CLOCK_50),
        .i_rst   (rst),
        .i_load  (w_load),
        .i_x0    (fill_x0),
        .i_y0    (fill_y0),
        .i_x1    (fill_x1),
        .i_y1    (fill_y1),
        .i_step  (w_gnt_fill),
        .o_cx    (w_cx),
        .o_cy    (w_cy),
        .o_last  (w_last),
        .o_empty (w_empty)
    );

    assign w_host_ok = ({1'b0, host_x} < 9'(FB_W))
                    && ({1'b0, host_y} < 9'(FB_H));

    always_comb begin
        w_next       = r_state;
        host_ready   = 1'b0;
        w_gnt_host   = 1'b0;
        w_gnt_fill   = 1'b0;
        w_load       = 1'b0;
        w_empty_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                host_ready = 1'b1;
                w_gnt_host = host_valid;
                if (fill_start) begin
                    w_load = 1'b1;
                    if (w_empty)
                        w_empty_done = 1'b1;
                    else
                        w_next = FILL;
                end
            end
            FILL: begin
                // Strict alternation only when the host contends.
                host_ready = (r_last_grant == GNT_FILL);
                w_gnt_host = host_valid && host_ready;
                w_gnt_fill = !w_gnt_host;
                if ((w_gnt_fill && w_last) || fill_abort)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (rst)
            host_ready = 1'b0;
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_FILL;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_d          <= '0;
            r_done       <= 1'b0;
            r_fill_color <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_gnt_fill && w_last) || w_empty_done;
            if (w_load)
                r_fill_color <= fill_color;
            if (w_gnt_host)
                r_last_grant <= GNT_HOST;
            else if (w_gnt_fill)
                r_last_grant <= GNT_FILL;
            if (w_gnt_host) begin
                // Off-screen host pixels are accepted but dropped.
                r_we <= w_host_ok;
                if (w_host_ok) begin
                    r_adr <= ADR_W'(fb_addr(host_x, host_y, XBITS));
                    r_d   <= host_color;
                end
            end else if (w_gnt_fill) begin
                r_we  <= 1'b1;
                r_adr <= ADR_W'(fb_addr(w_cx, w_cy, XBITS));
                r_d   <= r_fill_color;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign fb_wclk   = ~CLOCK_50;
    assign fb_we     = r_we;
    assign fb_wadr   = r_adr;
    assign fb_d      = r_d;
    assign fill_done = r_done;
    assign fill_busy = (r_state == FILL);

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed self-checking bench for fb_write_ctrl (FB_W=128, FB_H=192).
// Hand-computed address/data vectors for host, fill, contention, abort, clip.
module tb_fb_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_valid;
    logic        host_ready;
    logic [7:0]  host_x;
    logic [7:0]  host_y;
    logic [23:0] host_color;
    logic        fill_start;
    logic        fill_abort;
    logic [7:0]  fill_x0;
    logic [7:0]  fill_y0;
    logic [7:0]  fill_x1;
    logic [7:0]  fill_y1;
    logic [23:0] fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic        fb_wclk;
    logic [15:0] fb_wadr;
    logic        fb_we;
    logic [23:0] fb_d;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fb_write_ctrl #(
        .FB_W  (128),
        .FB_H  (192),
        .ADR_W (16),
        .PIX_W (24)
    ) dut (
        .CLOCK_50   (clk),
        .rst        (rst),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_x     (host_x),
        .host_y     (host_y),
        .host_color (host_color),
        .fill_start (fill_start),
        .fill_abort (fill_abort),
        .fill_x0    (fill_x0),
        .fill_y0    (fill_y0),
        .fill_x1    (fill_x1),
        .fill_y1    (fill_y1),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fb_wclk    (fb_wclk),
        .fb_wadr    (fb_wadr),
        .fb_we      (fb_we),
        .fb_d       (fb_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input logic [7:0] x0, input logic [7:0] y0,
                              input logic [7:0] x1, input logic [7:0] y1,
                              input logic [23:0] c);
        fill_start = 1'b1;
        fill_x0    = x0;
        fill_y0    = y0;
        fill_x1    = x1;
        fill_y1    = y1;
        fill_color = c;
    endtask

    logic [15:0] exp_sw [8];
    logic [15:0] exp_ct [8];
    logic        exp_rdy [8];
    logic [15:0] exp_yc [4];
    int          k;
    int          nw;
    logic        hs;

    initial begin
        exp_sw = '{16'h0002, 16'h0003, 16'h0004, 16'h0005,
                   16'h0082, 16'h0083, 16'h0084, 16'h0085};
        exp_ct = '{16'h028A, 16'h0000, 16'h028B, 16'h0001,
                   16'h028C, 16'h0002, 16'h028D, 16'h0003};
        exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_yc = '{16'h5F00, 16'h5F01, 16'h5F80, 16'h5F81};

        rst        = 1'b1;
        host_valid = 1'b1;
        host_x     = 8'd0;
        host_y     = 8'd0;
        host_color = 24'h0;
        fill_start = 1'b0;
        fill_abort = 1'b0;
        fill_x0    = 8'd0;
        fill_y0    = 8'd0;
        fill_x1    = 8'd0;
        fill_y1    = 8'd0;
        fill_color = 24'h0;
        #1;
        chk("rst_ready", host_ready, 0);
        host_valid = 1'b0;
        cyc();
        cyc();
        chk("rst_we", fb_we, 0);
        chk("rst_adr", fb_wadr, 0);
        chk("rst_d", fb_d, 0);
        chk("rst_busy", fill_busy, 0);
        chk("rst_done", fill_done, 0);
        rst = 1'b0;
        cyc();

        // Host write (3,2) -> 2*128+3
        host_valid = 1'b1;
        host_x     = 8'd3;
        host_y     = 8'd2;
        host_color = 24'hFF0000;
        #1;
        chk("host_ready_idle", host_ready, 1);
        cyc();
        chk("host_we", fb_we, 1);
        chk("host_adr", fb_wadr, 16'h0103);
        chk("host_d", fb_d, 24'hFF0000);
        // Off-screen x: accepted, dropped
        host_x     = 8'd255;
        host_color = 24'h00FF00;
        #1;
        chk("drop_ready", host_ready, 1);
        cyc();
        host_valid = 1'b0;
        chk("drop_we", fb_we, 0);
        chk("drop_adr_hold", fb_wadr, 16'h0103);
        chk("drop_d_hold", fb_d, 24'hFF0000);
        cyc();

        // Swapped-corner fill (5,1)-(2,0)
        start_fill(8'd5, 8'd1, 8'd2, 8'd0, 24'h123456);
        cyc();
        fill_start = 1'b0;
        chk("sw_busy", fill_busy, 1);
        chk("sw_we0", fb_we, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("sw_we", fb_we, 1);
            chk("sw_adr", fb_wadr, exp_sw[i]);
            chk("sw_d", fb_d, 24'h123456);
            chk("sw_done", fill_done, (i == 7));
            chk("sw_busy", fill_busy, (i != 7));
        end
        cyc();
        chk("sw_after_we", fb_we, 0);
        chk("sw_after_done", fill_done, 0);

        // Contention: fill (0,0)-(3,0) with host (10..13,5) held valid
        k = 0;
        start_fill(8'd0, 8'd0, 8'd3, 8'd0, 24'h0000AA);
        for (int c = 0; c < 8; c++) begin
            host_valid = (k < 4);
            host_x     = 8'(10 + k);
            host_y     = 8'd5;
            host_color = 24'hBB0000 + 24'(k);
            #1;
            if (c < 7)
                chk("ct_ready", host_ready, exp_rdy[c]);
            hs = host_valid && host_ready;
            cyc();
            fill_start = 1'b0;
            if (hs)
                k++;
            chk("ct_we", fb_we, 1);
            chk("ct_adr", fb_wadr, exp_ct[c]);
            chk("ct_done", fill_done, (c == 7));
        end
        host_valid = 1'b0;
        chk("ct_host_count", k, 4);
        cyc();
        chk("ct_after_we", fb_we, 0);

        // Abort a full-screen fill on its 10th grant
        nw = 0;
        start_fill(8'd0, 8'd0, 8'd255, 8'd255, 24'h00CC00);
        cyc();
        fill_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9)
                fill_abort = 1'b1;
            cyc();
            fill_abort = 1'b0;
            if (fb_we)
                nw++;
            if (fill_done)
                chk("ab_no_done", fill_done, 0);
        end
        chk("ab_writes", nw, 10);
        chk("ab_last_adr", fb_wadr, 16'h0009);
        chk("ab_busy", fill_busy, 0);
        chk("ab_done", fill_done, 0);

        // Immediate restart: x clipped to 127
        start_fill(8'd126, 8'd0, 8'd200, 8'd0, 24'h0F0F0F);
        cyc();
        fill_start = 1'b0;
        chk("xc_busy", fill_busy, 1);
        chk("xc_we0", fb_we, 0);
        cyc();
        chk("xc_adr0", fb_wadr, 16'h007E);
        chk("xc_done0", fill_done, 0);
        cyc();
        chk("xc_adr1", fb_wadr, 16'h007F);
        chk("xc_done1", fill_done, 1);
        cyc();
        chk("xc_after_we", fb_we, 0);

        // y clipped to 191
        start_fill(8'd0, 8'd190, 8'd1, 8'd250, 24'h555555);
        cyc();
        fill_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("yc_we", fb_we, 1);
            chk("yc_adr", fb_wadr, exp_yc[i]);
            chk("yc_done", fill_done, (i == 3));
        end
        cyc();
        chk("yc_after_we", fb_we, 0);

        // Fully off-screen rectangle: immediate done, no writes
        start_fill(8'd200, 8'd0, 8'd220, 8'd5, 24'h777777);
        cyc();
        fill_start = 1'b0;
        chk("em_done", fill_done, 1);
        chk("em_busy", fill_busy, 0);
        chk("em_we", fb_we, 0);
        cyc();
        chk("em_done_clr", fill_done, 0);

        // Reset in the middle of a fill
        start_fill(8'd0, 8'd0, 8'd9, 8'd9, 24'hABCDEF);
        cyc();
        fill_start = 1'b0;
        for (int i = 0; i < 5; i++)
            cyc();
        chk("mr_pre_adr", fb_wadr, 16'h0004);
        host_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("mr_we", fb_we, 0);
        chk("mr_adr", fb_wadr, 0);
        chk("mr_d", fb_d, 0);
        chk("mr_busy", fill_busy, 0);
        chk("mr_done", fill_done, 0);
        chk("mr_ready", host_ready, 0);
        host_valid = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("mr_post_busy", fill_busy, 0);
        chk("mr_post_we", fb_we, 0);
        host_valid = 1'b1;
        #1;
        chk("mr_post_ready", host_ready, 1);
        host_valid = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
